// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the pipelined control unit.
//   - instruction field positions
//   - opcode and R-type aluop constants
//   - ctrl_t stage control bundle and the all-zero bubble
package ctrl_pkg;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 27;
   localparam int RD_HI  = 26;
   localparam int RD_LO  = 22;
   localparam int RS_HI  = 21;
   localparam int RS_LO  = 17;
   localparam int RT_HI  = 16;
   localparam int RT_LO  = 12;
   localparam int ALU_HI = 6;
   localparam int ALU_LO = 2;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00001;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SETX  = 5'b10101;
   localparam logic [4:0] OP_BEX   = 5'b10110;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_AND = 5'b00010;
   localparam logic [4:0] ALU_OR  = 5'b00011;
   localparam logic [4:0] ALU_SLL = 5'b00100;
   localparam logic [4:0] ALU_SRA = 5'b00101;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;
   localparam logic [4:0] ALU_NOP = 5'b01000;

   localparam logic [4:0] REG_RA     = 5'd31;
   localparam logic [4:0] REG_STATUS = 5'd30;

   typedef struct packed {
      logic [4:0] aluOp;
      logic       aluInB;
      logic       br;
      logic       brLt;
      logic       jp;
      logic       jr;
      logic       isMd;
      logic       dMwe;
      logic       rwd;
      logic       we;
      logic       jal;
      logic       wtToReg;
      logic [4:0] dest;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   function automatic logic isMulDiv(input logic [4:0] aluOp);
      return (aluOp == ALU_MUL) || (aluOp == ALU_DIV);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational decode of the instruction held in D.
// Ports:
//   insn     in  instruction word from the F/D latch
//   valid    in  D holds a real instruction; low decodes as a bubble
//   ctrl     out control bundle for this instruction
//   usesRs/usesRt/usesRd/usesR30  out  which source registers D reads
//   rsAddr/rtAddr/rdAddr          out  raw register fields
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int INSN_W = 32
) (
   input  logic [INSN_W-1:0] insn,
   input  logic              valid,
   output ctrl_t             ctrl,
   output logic              usesRs,
   output logic              usesRt,
   output logic              usesRd,
   output logic              usesR30,
   output logic [4:0]        rsAddr,
   output logic [4:0]        rtAddr,
   output logic [4:0]        rdAddr
);

   logic [4:0] opcode;
   logic [4:0] aluFld;
   logic       unusedBits;

   assign opcode     = insn[OP_HI:OP_LO];
   assign aluFld     = insn[ALU_HI:ALU_LO];
   assign rdAddr     = insn[RD_HI:RD_LO];
   assign rsAddr     = insn[RS_HI:RS_LO];
   assign rtAddr     = insn[RT_HI:RT_LO];
   assign unusedBits = ^{insn[11:7], insn[1:0]};

   always_comb begin
      ctrl    = CTRL_BUBBLE;
      usesRs  = 1'b0;
      usesRt  = 1'b0;
      usesRd  = 1'b0;
      usesR30 = 1'b0;
      if (valid) begin
         case (opcode)
            OP_RTYPE: begin
               case (aluFld)
                  ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
                  ALU_SLL, ALU_SRA, ALU_MUL, ALU_DIV: begin
                     ctrl.aluOp = aluFld;
                     ctrl.isMd  = isMulDiv(aluFld);
                     ctrl.we    = 1'b1;
                     ctrl.dest  = rdAddr;
                     usesRs     = 1'b1;
                     usesRt     = 1'b1;
                  end
                  ALU_NOP: ;
                  default: ;
               endcase
            end
            OP_ADDI: begin
               ctrl.aluOp  = ALU_ADD;
               ctrl.aluInB = 1'b1;
               ctrl.we     = 1'b1;
               ctrl.dest   = rdAddr;
               usesRs      = 1'b1;
            end
            OP_LW: begin
               ctrl.aluOp  = ALU_ADD;
               ctrl.aluInB = 1'b1;
               ctrl.rwd    = 1'b1;
               ctrl.we     = 1'b1;
               ctrl.dest   = rdAddr;
               usesRs      = 1'b1;
            end
            OP_SW: begin
               ctrl.aluOp  = ALU_ADD;
               ctrl.aluInB = 1'b1;
               ctrl.dMwe   = 1'b1;
               usesRs      = 1'b1;
               usesRd      = 1'b1;
            end
            OP_J: ctrl.jp = 1'b1;
            OP_BNE: begin
               ctrl.aluOp = ALU_SUB;
               ctrl.br    = 1'b1;
               usesRs     = 1'b1;
               usesRt     = 1'b1;
            end
            OP_BLT: begin
               ctrl.aluOp = ALU_SUB;
               ctrl.br    = 1'b1;
               ctrl.brLt  = 1'b1;
               usesRs     = 1'b1;
               usesRt     = 1'b1;
            end
            OP_JAL: begin
               ctrl.jp   = 1'b1;
               ctrl.jal  = 1'b1;
               ctrl.we   = 1'b1;
               ctrl.dest = REG_RA;
            end
            OP_JR: begin
               ctrl.jr = 1'b1;
               usesRd  = 1'b1;
            end
            // bex jumps through the register path when r30 is nonzero
            OP_BEX: begin
               ctrl.jr = 1'b1;
               usesR30 = 1'b1;
            end
            OP_SETX: begin
               ctrl.we      = 1'b1;
               ctrl.wtToReg = 1'b1;
               ctrl.dest    = REG_STATUS;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pipe_control.sv
// pipe_control: stage-aligned control for the five-stage pipeline.
// Decodes D, registers the bundle through X/M/W, and produces the
// load-use stall, the mul/div occupancy stall and the redirect squash.
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   d_insn, d_valid         instruction in D
//   x_redirect              taken branch/jump resolved in X
//   fd_stall                hold PC and F/D latch
//   md_start, md_busy       mul/div launch pulse and occupancy
//   x_ctrl, m_ctrl, w_ctrl  stage control bundles
//
// Mul/div FSM:
//   state   | meaning
//   MD_IDLE | X free, or a mul/div in its final X cycle
//   MD_RUN  | mul/div held in X, D stalled, bubbles into M
module pipe_control
   import ctrl_pkg::*;
#(
   parameter int INSN_W  = 32,
   parameter int REG_AW  = 5,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [INSN_W-1:0] d_insn,
   input  logic              d_valid,
   input  logic              x_redirect,
   output logic              fd_stall,
   output logic              md_start,
   output logic              md_busy,
   output ctrl_t             x_ctrl,
   output ctrl_t             m_ctrl,
   output ctrl_t             w_ctrl
);

   localparam logic [0:0] MD_IDLE = 1'b0;
   localparam logic [0:0] MD_RUN  = 1'b1;

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   ctrl_t             dCtrl;
   logic              usesRs, usesRt, usesRd, usesR30;
   logic [4:0]        rsAddr, rtAddr, rdAddr;
   logic [0:0]        mdState;
   logic [CNT_W-1:0]  mdCnt;
   logic [CNT_W-1:0]  mdLoad;
   logic              mdFirst;
   logic              loadUse, squash, dAdvance, mdEnter;
   logic [REG_AW-1:0] xDest;

   ctrl_decode #(.INSN_W(INSN_W)) u_decode (
      .insn    (d_insn),
      .valid   (d_valid),
      .ctrl    (dCtrl),
      .usesRs  (usesRs),
      .usesRt  (usesRt),
      .usesRd  (usesRd),
      .usesR30 (usesR30),
      .rsAddr  (rsAddr),
      .rtAddr  (rtAddr),
      .rdAddr  (rdAddr)
   );

   assign xDest    = x_ctrl.dest;
   assign md_busy  = (mdState == MD_RUN);
   assign md_start = mdFirst;

   always_comb begin
      loadUse = x_ctrl.rwd && x_ctrl.we && (xDest != '0) &&
                ((usesRs  && (rsAddr == xDest)) ||
                 (usesRt  && (rtAddr == xDest)) ||
                 (usesRd  && (rdAddr == xDest)) ||
                 (usesR30 && (xDest == REG_STATUS)));
   end

   // Priority: mul/div occupancy, then redirect squash, then load-use.
   // A redirect supersedes the load-use stall since D is discarded anyway.
   assign squash   = x_redirect && !md_busy;
   assign fd_stall = md_busy || (!squash && loadUse);
   assign dAdvance = !md_busy && !squash && !loadUse;
   assign mdEnter  = dAdvance && dCtrl.isMd;
   assign mdLoad   = (dCtrl.aluOp == ALU_MUL) ? MUL_LOAD : DIV_LOAD;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         x_ctrl <= CTRL_BUBBLE;
         m_ctrl <= CTRL_BUBBLE;
         w_ctrl <= CTRL_BUBBLE;
      end else begin
         w_ctrl <= m_ctrl;
         if (md_busy) begin
            m_ctrl <= CTRL_BUBBLE;
         end else begin
            m_ctrl <= x_ctrl;
            x_ctrl <= dAdvance ? dCtrl : CTRL_BUBBLE;
         end
      end
   end

   // mdCnt counts the X cycles still owed after the current one. It is
   // loaded as the op enters X; RUN ends on the edge where it reaches zero,
   // leaving one final unstalled X cycle so the next op can enter with no gap.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mdState <= MD_IDLE;
         mdCnt   <= '0;
         mdFirst <= 1'b0;
      end else begin
         mdFirst <= mdEnter;
         case (mdState)
            MD_IDLE: begin
               if (mdEnter) begin
                  mdCnt <= mdLoad;
                  if (mdLoad != '0) mdState <= MD_RUN;
               end
            end
            MD_RUN: begin
               mdCnt <= mdCnt - CNT_ONE;
               if (mdCnt == CNT_ONE) mdState <= MD_IDLE;
            end
            default: mdState <= MD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_control.sv
module tb_pipe_control;
   import ctrl_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] dInsn;
   logic        dValid;
   logic        xRedirect;
   logic        fdStall, mdStart, mdBusy;
   ctrl_t       xCtrl, mCtrl, wCtrl;

   int assertCnt = 0;
   int failCnt   = 0;

   pipe_control #(.INSN_W(32), .REG_AW(5), .MUL_LAT(4), .DIV_LAT(32)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .d_insn     (dInsn),
      .d_valid    (dValid),
      .x_redirect (xRedirect),
      .fd_stall   (fdStall),
      .md_start   (mdStart),
      .md_busy    (mdBusy),
      .x_ctrl     (xCtrl),
      .m_ctrl     (mCtrl),
      .w_ctrl     (wCtrl)
   );

   always #5 clock = ~clock;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCnt++;
      if (obs !== exp) begin
         failCnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cw(input ctrl_t c);
      return {11'd0, c};
   endfunction

   function automatic logic [31:0] bw(input logic b);
      return {31'd0, b};
   endfunction

   function automatic logic [31:0] rIns(input logic [4:0] alu, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
      return {OP_RTYPE, rd, rs, rt, 5'd0, alu, 2'b00};
   endfunction

   function automatic logic [31:0] iIns(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction

   function automatic logic [31:0] jIns(input logic [4:0] op, input logic [26:0] tgt);
      return {op, tgt};
   endfunction

   // Drive D for the cycle following the next rising edge; sample 2 ns in.
   task automatic step(input logic [31:0] insn, input logic vld, input logic redir);
      @(posedge clock);
      #1;
      dInsn     = insn;
      dValid    = vld;
      xRedirect = redir;
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkVal({tag, "_fd_stall"}, bw(fdStall), 32'd0);
      checkVal({tag, "_md_start"}, bw(mdStart), 32'd0);
      checkVal({tag, "_md_busy"},  bw(mdBusy),  32'd0);
      checkVal({tag, "_x_ctrl"},   cw(xCtrl),   32'd0);
      checkVal({tag, "_m_ctrl"},   cw(mCtrl),   32'd0);
      checkVal({tag, "_w_ctrl"},   cw(wCtrl),   32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ctrl_t add1Exp, add6Exp, add11Exp, mulExp, divExp, lw4Exp, bneExp;
      ctrl_t jalExp, setxExp, bexExp;
      logic [31:0] lst [2];
      int startCnt, busyCnt, stallCnt, bubbleM, startK0, startK1, divMK, idx;
      logic prevStall, seen;

      add1Exp  = '0; add1Exp.we  = 1'b1; add1Exp.dest  = 5'd1;
      add6Exp  = '0; add6Exp.we  = 1'b1; add6Exp.dest  = 5'd6;
      add11Exp = '0; add11Exp.we = 1'b1; add11Exp.dest = 5'd11;
      mulExp   = '0; mulExp.aluOp = ALU_MUL; mulExp.isMd = 1'b1; mulExp.we = 1'b1; mulExp.dest = 5'd8;
      divExp   = '0; divExp.aluOp = ALU_DIV; divExp.isMd = 1'b1; divExp.we = 1'b1; divExp.dest = 5'd2;
      lw4Exp   = '0; lw4Exp.aluInB = 1'b1; lw4Exp.rwd = 1'b1; lw4Exp.we = 1'b1; lw4Exp.dest = 5'd4;
      bneExp   = '0; bneExp.aluOp = ALU_SUB; bneExp.br = 1'b1;
      jalExp   = '0; jalExp.jp = 1'b1; jalExp.jal = 1'b1; jalExp.we = 1'b1; jalExp.dest = 5'd31;
      setxExp  = '0; setxExp.we = 1'b1; setxExp.wtToReg = 1'b1; setxExp.dest = 5'd30;
      bexExp   = '0; bexExp.jr = 1'b1;

      reset_n = 1'b0; dInsn = '0; dValid = 1'b0; xRedirect = 1'b0;
      repeat (2) @(posedge clock);
      #2;
      checkAllZero("reset");
      @(negedge clock);
      reset_n = 1'b1;

      // load-use: lw r4,0(r5) then add r6,r4,r7
      step(iIns(OP_LW, 5'd4, 5'd5, 17'd0), 1'b1, 1'b0);
      step(rIns(ALU_ADD, 5'd6, 5'd4, 5'd7), 1'b1, 1'b0);
      checkVal("lu_stall", bw(fdStall), 32'd1);
      step(rIns(ALU_ADD, 5'd6, 5'd4, 5'd7), 1'b1, 1'b0);
      checkVal("lu_bubble_x", cw(xCtrl), 32'd0);
      checkVal("lu_release", bw(fdStall), 32'd0);
      step('0, 1'b0, 1'b0);
      checkVal("lu_add_x", cw(xCtrl), cw(add6Exp));
      step('0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      checkVal("lu_add_w", cw(wCtrl), cw(add6Exp));

      // lw to r0 never stalls
      step(iIns(OP_LW, 5'd0, 5'd5, 17'd0), 1'b1, 1'b0);
      step(rIns(ALU_ADD, 5'd6, 5'd0, 5'd7), 1'b1, 1'b0);
      checkVal("lu_r0_nostall", bw(fdStall), 32'd0);
      step('0, 1'b0, 1'b0);
      checkVal("lu_r0_add_x", cw(xCtrl), cw(add6Exp));

      // mul r8,r9,r10 followed by add r11,r1,r2
      step('0, 1'b0, 1'b0);
      step(rIns(ALU_MUL, 5'd8, 5'd9, 5'd10), 1'b1, 1'b0);
      startCnt = 0; busyCnt = 0; stallCnt = 0; bubbleM = 0; startK0 = 0;
      for (int k = 1; k <= 5; k++) begin
         step((k < 5) ? rIns(ALU_ADD, 5'd11, 5'd1, 5'd2) : 32'd0, (k < 5), 1'b0);
         if (mdStart) begin startCnt++; startK0 = k; end
         if (mdBusy)  busyCnt++;
         if (fdStall) stallCnt++;
         if (k >= 2 && k <= 4 && mCtrl == CTRL_BUBBLE) bubbleM++;
      end
      checkVal("mul_start_cnt", 32'(startCnt), 32'd1);
      checkVal("mul_start_cycle", 32'(startK0), 32'd1);
      checkVal("mul_busy_cnt", 32'(busyCnt), 32'd3);
      checkVal("mul_stall_cnt", 32'(stallCnt), 32'd3);
      checkVal("mul_m_bubbles", 32'(bubbleM), 32'd3);
      checkVal("mul_in_m", cw(mCtrl), cw(mulExp));
      checkVal("mul_next_x", cw(xCtrl), cw(add11Exp));

      // back-to-back mul r1,r2,r3 then div r2,r3,r4 with a stall-aware fetch
      repeat (3) step('0, 1'b0, 1'b0);
      lst[0] = rIns(ALU_MUL, 5'd1, 5'd2, 5'd3);
      lst[1] = rIns(ALU_DIV, 5'd2, 5'd3, 5'd4);
      idx = 0;
      step(lst[0], 1'b1, 1'b0);
      prevStall = fdStall;
      startCnt = 0; stallCnt = 0; startK0 = 0; startK1 = 0; divMK = 0;
      for (int k = 1; k <= 40; k++) begin
         if (!prevStall) idx++;
         step((idx < 2) ? lst[idx] : 32'd0, (idx < 2), 1'b0);
         if (mdStart) begin
            startCnt++;
            if (startCnt == 1) startK0 = k;
            else startK1 = k;
         end
         if (fdStall) stallCnt++;
         if (divMK == 0 && mCtrl == divExp) divMK = k;
         prevStall = fdStall;
      end
      checkVal("b2b_start_cnt", 32'(startCnt), 32'd2);
      checkVal("b2b_start_gap", 32'(startK1 - startK0), 32'd4);
      checkVal("b2b_stall_cnt", 32'(stallCnt), 32'd34);
      checkVal("b2b_div_in_m", 32'(divMK), 32'd37);

      // redirect squashes the add in D
      step(iIns(OP_BNE, 5'd0, 5'd1, {5'd2, 12'd4}), 1'b1, 1'b0);
      step(rIns(ALU_ADD, 5'd12, 5'd1, 5'd2), 1'b1, 1'b1);
      checkVal("rd_bne_x", cw(xCtrl), cw(bneExp));
      checkVal("rd_nostall", bw(fdStall), 32'd0);
      step('0, 1'b0, 1'b0);
      checkVal("rd_bubble_x", cw(xCtrl), 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step('0, 1'b0, 1'b0);
         if (wCtrl.we && wCtrl.dest == 5'd12) seen = 1'b1;
      end
      checkVal("rd_add_never_w", bw(seen), 32'd0);

      // redirect coinciding with load-use
      step(iIns(OP_LW, 5'd4, 5'd5, 17'd0), 1'b1, 1'b0);
      step(rIns(ALU_ADD, 5'd6, 5'd4, 5'd7), 1'b1, 1'b1);
      checkVal("rdlu_nostall", bw(fdStall), 32'd0);
      step('0, 1'b0, 1'b0);
      checkVal("rdlu_bubble_x", cw(xCtrl), 32'd0);
      checkVal("rdlu_lw_m", cw(mCtrl), cw(lw4Exp));

      // dest mapping: jal, setx, bex
      step(jIns(OP_JAL, 27'd100), 1'b1, 1'b0);
      step(jIns(OP_SETX, 27'd5), 1'b1, 1'b0);
      step(jIns(OP_BEX, 27'd40), 1'b1, 1'b0);
      step('0, 1'b0, 1'b0);
      checkVal("map_bex_x", cw(xCtrl), cw(bexExp));
      checkVal("map_jal_w", cw(wCtrl), cw(jalExp));
      step('0, 1'b0, 1'b0);
      checkVal("map_setx_w", cw(wCtrl), cw(setxExp));
      step('0, 1'b0, 1'b0);
      checkVal("map_bex_w", cw(wCtrl), cw(bexExp));

      // bex reads r30 for the load-use compare
      step(iIns(OP_LW, 5'd30, 5'd5, 17'd0), 1'b1, 1'b0);
      step(jIns(OP_BEX, 27'd40), 1'b1, 1'b0);
      checkVal("bex_r30_stall", bw(fdStall), 32'd1);
      step(jIns(OP_BEX, 27'd40), 1'b1, 1'b0);
      checkVal("bex_r30_bubble", cw(xCtrl), 32'd0);
      step('0, 1'b0, 1'b0);
      checkVal("bex_r30_enter", cw(xCtrl), cw(bexExp));

      // asynchronous reset while a div is running
      step(rIns(ALU_DIV, 5'd2, 5'd3, 5'd4), 1'b1, 1'b0);
      step('0, 1'b0, 1'b0);
      repeat (3) step('0, 1'b0, 1'b0);
      checkVal("rst_div_busy", bw(mdBusy), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkAllZero("rst_async");
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      step(rIns(ALU_ADD, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0);
      step('0, 1'b0, 1'b0);
      checkVal("rst_add_x", cw(xCtrl), cw(add1Exp));
      step('0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      checkVal("rst_add_w", cw(wCtrl), cw(add1Exp));
      checkVal("rst_busy_clear", bw(mdBusy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule
